// File: rtl/trail_pkg.sv
// Constants shared by the trail framebuffer scanout and the player blocks:
// screen geometry, trail byte codes, their colours and the collision query states.
package trail_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    localparam logic [7:0] EMPTY_CODE = 8'h00;
    localparam logic [7:0] P1_CODE    = 8'hFF;
    localparam logic [7:0] P2_CODE    = 8'h80;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t RGB_P1    = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t RGB_P2    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

    typedef enum logic [1:0] {
        COLL_IDLE  = 2'd0,
        COLL_ISSUE = 2'd1,
        COLL_WAIT  = 2'd2,
        COLL_DONE  = 2'd3
    } coll_state_e;

    // Unknown nonzero bytes still mark an occupied cell, so they show as white.
    function automatic rgb_t trail_colour(input logic [7:0] code);
        rgb_t c;
        if (code == EMPTY_CODE)   c = RGB_BLACK;
        else if (code == P1_CODE) c = RGB_P1;
        else if (code == P2_CODE) c = RGB_P2;
        else                      c = RGB_WHITE;
        return c;
    endfunction

    // y*640 as y*512 + y*128, so no multiplier is needed.
    function automatic logic [18:0] line_base(input logic [9:0] y);
        return {y, 9'b0} + {2'b00, y, 7'b0};
    endfunction

endpackage

// File: rtl/trail_palette.sv
// Registered map from a stored trail byte to 24-bit RGB; pixels without a valid
// read tag are forced to black. Also carries the visible flag to stay aligned.
module trail_palette
    import trail_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tag_i,
    input  logic       vis_i,
    input  logic [7:0] code_i,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       vis_o
);

    rgb_t rgb_d, rgb_q;
    logic vis_d, vis_q;

    always_comb begin
        rgb_d = RGB_BLACK;
        vis_d = vis_i;
        if (tag_i) begin
            rgb_d = trail_colour(code_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= RGB_BLACK;
            vis_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            vis_q <= vis_d;
        end
    end

    assign red_o   = rgb_q.r;
    assign green_o = rgb_q.g;
    assign blue_o  = rgb_q.b;
    assign vis_o   = vis_q;

endmodule

// File: rtl/trail_scanout.sv
// Read side of the 640x480 trail framebuffer: one RAM read per visible pixel,
// latency-compensated colour output, and a collision query served in blanking.
module trail_scanout
    import trail_pkg::*;
#(
    parameter int RAM_LAT = 2
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    input  logic        vis_in,
    output logic [18:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic [7:0]  OUT_R,
    output logic [7:0]  OUT_G,
    output logic [7:0]  OUT_B,
    output logic        vis_out,
    input  logic        coll_req,
    input  logic [18:0] coll_addr,
    output logic        coll_ack,
    output logic        coll_hit
);

    localparam logic [1:0] WCNT_INIT = 2'(RAM_LAT - 1);

    // ---------------- scan address generation ----------------
    logic        scan_rd;
    logic [18:0] scan_addr_now;
    logic        scan_prev_d, scan_prev_q;
    logic [18:0] scan_addr_d, scan_addr_q;

    // Out-of-range coordinates are treated as blanking for the read path.
    assign scan_rd = vis_in && (next_x < 10'(H_RES)) && (next_y < 10'(V_RES));

    always_comb begin
        scan_addr_now = scan_prev_q ? scan_addr_q
                                    : (line_base(next_y) + {9'b0, next_x});
        scan_prev_d   = scan_rd;
        scan_addr_d   = scan_rd ? (scan_addr_now + 19'd1) : scan_addr_q;
    end

    // ---------------- tag / visible pipeline ----------------
    logic [RAM_LAT-1:0] tag_d, tag_q;
    logic [RAM_LAT-1:0] vis_pipe_d, vis_pipe_q;

    always_comb begin
        tag_d         = tag_q;
        vis_pipe_d    = vis_pipe_q;
        tag_d[0]      = scan_rd;
        vis_pipe_d[0] = vis_in;
        for (int i = 1; i < RAM_LAT; i++) begin
            tag_d[i]      = tag_q[i-1];
            vis_pipe_d[i] = vis_pipe_q[i-1];
        end
    end

    // ---------------- collision query FSM ----------------
    // Handshake: the requester raises coll_req with a stable coll_addr and holds
    // both until coll_ack pulses for one cycle; coll_hit is valid from that cycle
    // on and holds until the next ack. coll_req still high after ack is a new query.
    coll_state_e state_d, state_q;
    logic [1:0]  wcnt_d, wcnt_q;
    logic        hit_d, hit_q;
    logic        issue;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hit_d   = hit_q;
        issue   = 1'b0;
        case (state_q)
            COLL_IDLE: begin
                if (coll_req && !vis_in) state_d = COLL_ISSUE;
            end
            COLL_ISSUE: begin
                // A line starting now takes the port back; retry from IDLE.
                if (vis_in) begin
                    state_d = COLL_IDLE;
                end else begin
                    issue   = 1'b1;
                    wcnt_d  = WCNT_INIT;
                    state_d = COLL_WAIT;
                end
            end
            COLL_WAIT: begin
                if (wcnt_q == 2'd0) begin
                    hit_d   = (ram_q != EMPTY_CODE);
                    state_d = COLL_DONE;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            COLL_DONE: begin
                state_d = COLL_IDLE;
            end
            default: begin
                state_d = COLL_IDLE;
            end
        endcase
    end

    assign coll_ack = (state_q == COLL_DONE);
    assign coll_hit = hit_q;

    // ---------------- RAM port arbitration ----------------
    always_comb begin
        ram_addr = '0;
        if (!reset_n) begin
            ram_addr = '0;
        end else if (scan_rd) begin
            ram_addr = scan_addr_now;
        end else if (issue) begin
            ram_addr = coll_addr;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            scan_prev_q <= 1'b0;
            scan_addr_q <= '0;
            tag_q       <= '0;
            vis_pipe_q  <= '0;
            state_q     <= COLL_IDLE;
            wcnt_q      <= 2'd0;
            hit_q       <= 1'b0;
        end else begin
            scan_prev_q <= scan_prev_d;
            scan_addr_q <= scan_addr_d;
            tag_q       <= tag_d;
            vis_pipe_q  <= vis_pipe_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            hit_q       <= hit_d;
        end
    end

    trail_palette u_palette (
        .clk     (VGA_CLK),
        .rst_n   (reset_n),
        .tag_i   (tag_q[RAM_LAT-1]),
        .vis_i   (vis_pipe_q[RAM_LAT-1]),
        .code_i  (ram_q),
        .red_o   (OUT_R),
        .green_o (OUT_G),
        .blue_o  (OUT_B),
        .vis_o   (vis_out)
    );

endmodule

// File: tb/tb_trail_scanout.sv
// Bench for trail_scanout: RAM model with fixed read latency, pixel scoreboard,
// and hand-written collision query sequences.
module tb_trail_scanout;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  next_x, next_y;
    logic        vis_in;
    logic [18:0] ram_addr;
    logic [7:0]  ram_q;
    logic [7:0]  OUT_R, OUT_G, OUT_B;
    logic        vis_out;
    logic        coll_req;
    logic [18:0] coll_addr;
    logic        coll_ack, coll_hit;

    int total = 0;
    int bad   = 0;

    logic [24:0] exp_q[$];
    logic [7:0]  mem [int];

    int   cyc     = 0;
    int   ack_cnt = 0;
    int   ack_cyc = 0;
    logic ack_hit = 1'b0;

    trail_scanout #(.RAM_LAT(LAT)) dut (
        .VGA_CLK   (clk),
        .reset_n   (reset_n),
        .next_x    (next_x),
        .next_y    (next_y),
        .vis_in    (vis_in),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .OUT_R     (OUT_R),
        .OUT_G     (OUT_G),
        .OUT_B     (OUT_B),
        .vis_out   (vis_out),
        .coll_req  (coll_req),
        .coll_addr (coll_addr),
        .coll_ack  (coll_ack),
        .coll_hit  (coll_hit)
    );

    // ---------------- clock ----------------
    always #20 clk = ~clk;

    // ---------------- RAM model: data two cycles after address ----------------
    function automatic logic [7:0] rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    logic [18:0] a1 = '0;
    always @(posedge clk) begin
        a1    <= ram_addr;
        ram_q <= rd(int'(a1));
    end

    // ---------------- ack monitor ----------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (coll_ack) begin
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc;
            ack_hit <= coll_hit;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [23:0] pal(input logic [7:0] d);
        case (d)
            8'h00:   return 24'h000000;
            8'hFF:   return 24'hFFFF00;
            8'h80:   return 24'h00FFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'h3C;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The requester drops coll_req as soon as it sees the ack.
    task automatic tick();
        @(negedge clk);
        if (coll_ack) coll_req = 1'b0;
    endtask

    task automatic pop_check();
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("pix_vis", {31'b0, vis_out}, {31'b0, e[24]});
        chk("pix_rgb", {8'b0, OUT_R, OUT_G, OUT_B}, {8'b0, e[23:0]});
    endtask

    // Drive one pixel slot; compares the slot that left the pipeline LAT+1 ago.
    task automatic pix(input logic v, input int x, input int y,
                       input logic [24:0] e, input int exp_addr);
        if (exp_q.size() == LAT + 1) pop_check();
        vis_in = v;
        next_x = x[9:0];
        next_y = y[9:0];
        exp_q.push_back(e);
        if (exp_addr >= 0) begin
            #1;
            chk("ram_addr", {13'b0, ram_addr}, exp_addr);
        end
        tick();
    endtask

    task automatic flush();
        vis_in = 1'b0;
        while (exp_q.size() > 0) begin
            pop_check();
            tick();
        end
    endtask

    task automatic wait_ack(input int n0);
        int k;
        k = 0;
        while (ack_cnt == n0 && k < 40) begin
            tick();
            k++;
        end
        chk("ack_seen", {31'b0, (ack_cnt != n0)}, 32'd1);
    endtask

    typedef struct {
        logic        vis;
        int          x;
        int          y;
        int          wr_addr;
        logic [7:0]  data;
        logic [23:0] rgb;
        int          exp_addr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n0, start;
        logic [7:0] d;

        tbl[0] = '{1'b1,  10,  20,  12810, 8'h00, 24'h000000,  12810};
        tbl[1] = '{1'b1,  11,  20,  12811, 8'hFF, 24'hFFFF00,  12811};
        tbl[2] = '{1'b1, 639, 479, 307199, 8'h80, 24'h00FFFF, 307199};
        tbl[3] = '{1'b1, 100, 200, 128100, 8'h3C, 24'hFFFFFF, 128100};
        tbl[4] = '{1'b0,   5,   5,      0, 8'hFF, 24'h000000,     -1};
        tbl[5] = '{1'b1, 640,  10,     -1, 8'h00, 24'h000000,     -1};
        tbl[6] = '{1'b1,   5, 480,     -1, 8'h00, 24'h000000,     -1};

        // ---- reset with vis_in high ----
        reset_n   = 1'b0;
        vis_in    = 1'b1;
        next_x    = 10'd5;
        next_y    = 10'd2;
        coll_req  = 1'b0;
        coll_addr = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_rgb", {8'b0, OUT_R, OUT_G, OUT_B}, 32'd0);
            chk("rst_vis", {31'b0, vis_out}, 32'd0);
            chk("rst_ack", {31'b0, coll_ack}, 32'd0);
            chk("rst_hit", {31'b0, coll_hit}, 32'd0);
            chk("rst_addr", {13'b0, ram_addr}, 32'd0);
            next_x = next_x + 10'd1;
            tick();
        end
        vis_in  = 1'b0;
        reset_n = 1'b1;
        tick();

        // ---- palette / boundary table: one-pixel visible pulses ----
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr_addr >= 0) mem[tbl[i].wr_addr] = tbl[i].data;
            pix(tbl[i].vis, tbl[i].x, tbl[i].y, {tbl[i].vis, tbl[i].rgb}, tbl[i].exp_addr);
            pix(1'b0, 0, 0, 25'd0, -1);
        end
        flush();

        // ---- line scan at y=3 ----
        for (int x = 0; x < 16; x++) begin
            d = (x == 5) ? 8'hFF : pick();
            mem[3 * 640 + x] = d;
        end
        pix(1'b0, 0, 3, 25'd0, -1);
        for (int x = 0; x < 16; x++) begin
            pix(1'b1, x, 3, {1'b1, pal(rd(3 * 640 + x))}, 3 * 640 + x);
        end
        pix(1'b0, 0, 3, 25'd0, -1);
        flush();

        // ---- collision query in blanking, RAM holds 80 ----
        mem[153920] = 8'h80;
        mem[1000]   = 8'h00;
        coll_addr = 19'd153920;
        coll_req  = 1'b1;
        n0    = ack_cnt;
        start = cyc;
        tick();
        chk("coll_issue_addr", {13'b0, ram_addr}, 32'd153920);
        wait_ack(n0);
        chk("coll_lat", ack_cyc - start, LAT + 2);
        chk("coll_hit1", {31'b0, ack_hit}, 32'd1);
        repeat (6) tick();
        chk("coll_once", ack_cnt - n0, 32'd1);
        chk("coll_hit_held", {31'b0, coll_hit}, 32'd1);

        // ---- collision query, RAM holds 00 ----
        coll_addr = 19'd1000;
        coll_req  = 1'b1;
        n0    = ack_cnt;
        start = cyc;
        wait_ack(n0);
        chk("coll_lat0", ack_cyc - start, LAT + 2);
        chk("coll_hit0", {31'b0, ack_hit}, 32'd0);
        repeat (6) tick();
        chk("coll_once0", ack_cnt - n0, 32'd1);

        // ---- deferred query raised at line start ----
        mem[200000] = 8'h3C;
        for (int x = 0; x < 20; x++) mem[7 * 640 + x] = x[0] ? 8'hFF : 8'h80;
        pix(1'b0, 0, 7, 25'd0, -1);
        coll_addr = 19'd200000;
        coll_req  = 1'b1;
        n0 = ack_cnt;
        for (int x = 0; x < 20; x++) begin
            pix(1'b1, x, 7, {1'b1, pal(rd(7 * 640 + x))}, 7 * 640 + x);
        end
        chk("defer_no_ack", ack_cnt - n0, 32'd0);
        start = cyc;
        pix(1'b0, 0, 7, 25'd0, -1);
        flush();
        wait_ack(n0);
        chk("defer_lat_ok", {31'b0, (ack_cyc - start >= 1) && (ack_cyc - start <= LAT + 3)}, 32'd1);
        chk("defer_hit", {31'b0, ack_hit}, 32'd1);
        repeat (6) tick();
        chk("defer_once", ack_cnt - n0, 32'd1);

        // ---- reset while waiting for RAM data ----
        coll_addr = 19'd153920;
        coll_req  = 1'b1;
        n0 = ack_cnt;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rstw_ack", {31'b0, coll_ack}, 32'd0);
        tick();
        tick();
        chk("rstw_no_ack", ack_cnt - n0, 32'd0);
        chk("rstw_hit_clr", {31'b0, coll_hit}, 32'd0);
        reset_n = 1'b1;
        start = cyc;
        wait_ack(n0);
        chk("rstw_lat", ack_cyc - start, LAT + 2);
        chk("rstw_hit", {31'b0, ack_hit}, 32'd1);
        repeat (6) tick();
        chk("rstw_once", ack_cnt - n0, 32'd1);

        // ---- mid-line reset ----
        for (int x = 0; x < 8; x++) mem[9 * 640 + x] = pick();
        mem[9 * 640 + 2] = 8'hFF;
        pix(1'b0, 0, 9, 25'd0, -1);
        for (int x = 0; x < 6; x++) begin
            pix(1'b1, x, 9, {1'b1, pal(rd(9 * 640 + x))}, 9 * 640 + x);
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {8'b0, OUT_R, OUT_G, OUT_B}, 32'd0);
        chk("mid_rst_vis", {31'b0, vis_out}, 32'd0);
        exp_q.delete();
        tick();
        vis_in  = 1'b0;
        reset_n = 1'b1;
        tick();
        for (int x = 2; x < 8; x++) begin
            pix(1'b1, x, 9, {1'b1, pal(rd(9 * 640 + x))}, 9 * 640 + x);
        end
        pix(1'b0, 0, 9, 25'd0, -1);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
